// File: rtl/programmable_address_decoder.sv
// Purpose: run-time programmable base/mask address decoder with a bus-cycle watchdog for a 68k-style bus.
// Latency: Select_H/Hit_H valid on the 2nd rising Clock after AS_L falls; BusError_L drops one clock after DECODE/expiry.
// Backpressure: none; the bus cycle is paced by AS_L/Dtack_L, and a config write is accepted on every clock.
//
// Ports:
//   Clock, Reset_L                      rising-edge clock, async active-low reset
//   Address, AS_L, Dtack_L              CPU bus: address, address strobe (low), slave ack (low)
//   CfgWrite_H, CfgIndex, CfgIsMask_H,
//   CfgData                             one base-or-mask register write per clock
//   Select_H, Hit_H                     registered one-hot region select and its OR
//   BusError_L, ErrorAddress,
//   ErrorCount                          BERR (low), last faulted address, saturating fault count
module programmable_address_decoder #(
    parameter int NUM_REGIONS    = 8,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] RESET_BASE = {
        32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0050_0000,
        32'hF000_0000, 32'h0800_0000, 32'h0040_0000, 32'h0000_0000},
    parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] RESET_MASK = {
        32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_0000,
        32'hFFFC_0000, 32'hFC00_0000, 32'hFFFF_0000, 32'hFFFF_8000},
    localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
    input  logic                   Clock,
    input  logic                   Reset_L,
    input  logic [ADDR_WIDTH-1:0]  Address,
    input  logic                   AS_L,
    input  logic                   Dtack_L,
    input  logic                   CfgWrite_H,
    input  logic [IDX_W-1:0]       CfgIndex,
    input  logic                   CfgIsMask_H,
    input  logic [ADDR_WIDTH-1:0]  CfgData,
    output logic [NUM_REGIONS-1:0] Select_H,
    output logic                   Hit_H,
    output logic                   BusError_L,
    output logic [ADDR_WIDTH-1:0]  ErrorAddress,
    output logic [7:0]             ErrorCount
);

    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_DECODE   = 3'd1;
    localparam logic [2:0] S_WAIT_ACK = 3'd2;
    localparam logic [2:0] S_ACKED    = 3'd3;
    localparam logic [2:0] S_BERR     = 3'd4;

    logic [2:0]             state_q,    state_d;
    logic [NUM_REGIONS-1:0] select_q,   select_d;
    logic                   hit_q,      hit_d;
    logic                   berr_n_q,   berr_n_d;
    logic [ADDR_WIDTH-1:0]  err_addr_q, err_addr_d;
    logic [7:0]             err_cnt_q,  err_cnt_d;
    logic [TIMER_W-1:0]     timer_q,    timer_d;

    logic [ADDR_WIDTH-1:0]  base_q [NUM_REGIONS];
    logic [ADDR_WIDTH-1:0]  base_d [NUM_REGIONS];
    logic [ADDR_WIDTH-1:0]  mask_q [NUM_REGIONS];
    logic [ADDR_WIDTH-1:0]  mask_d [NUM_REGIONS];

    logic [NUM_REGIONS-1:0] match_vec;
    logic                   match_any;
    logic [7:0]             err_cnt_inc;

    // Priority match against the registered map. Scanning from the top down and
    // overwriting leaves only the lowest matching index set, so the result is
    // always zero or one-hot. A zero mask would match everything, so it disables.
    always_comb begin
        match_vec = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if ((mask_q[i] != '0) &&
                ((Address & mask_q[i]) == (base_q[i] & mask_q[i]))) begin
                match_vec    = '0;
                match_vec[i] = 1'b1;
            end
        end
    end

    assign match_any   = |match_vec;
    assign err_cnt_inc = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;

    // Config writes land at the clock edge, so a DECODE in the same clock still
    // sees the old map. Indices with no region simply match no write enable.
    always_comb begin
        for (int i = 0; i < NUM_REGIONS; i++) begin
            base_d[i] = base_q[i];
            mask_d[i] = mask_q[i];
            if (CfgWrite_H && (CfgIndex == IDX_W'(i))) begin
                if (CfgIsMask_H) begin
                    mask_d[i] = CfgData;
                end else begin
                    base_d[i] = CfgData;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        select_d   = select_q;
        hit_d      = hit_q;
        berr_n_d   = berr_n_q;
        err_addr_d = err_addr_q;
        err_cnt_d  = err_cnt_q;
        timer_d    = timer_q;

        case (state_q)
            S_IDLE: begin
                if (!AS_L) begin
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                timer_d = '0;
                if (AS_L) begin
                    state_d = S_IDLE;
                end else if (match_any) begin
                    // Select is latched here and held for the whole cycle, so
                    // later map writes cannot disturb the cycle in flight.
                    select_d = match_vec;
                    hit_d    = 1'b1;
                    state_d  = S_WAIT_ACK;
                end else begin
                    select_d   = '0;
                    hit_d      = 1'b0;
                    berr_n_d   = 1'b0;
                    err_addr_d = Address;
                    err_cnt_d  = err_cnt_inc;
                    state_d    = S_BERR;
                end
            end

            S_WAIT_ACK: begin
                if (AS_L) begin
                    select_d = '0;
                    hit_d    = 1'b0;
                    state_d  = S_IDLE;
                end else if (!Dtack_L) begin
                    // An ack arriving on the expiry clock still wins.
                    state_d = S_ACKED;
                end else if (timer_q == TIMER_LAST) begin
                    select_d   = '0;
                    hit_d      = 1'b0;
                    berr_n_d   = 1'b0;
                    err_addr_d = Address;
                    err_cnt_d  = err_cnt_inc;
                    state_d    = S_BERR;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            S_ACKED: begin
                if (AS_L) begin
                    select_d = '0;
                    hit_d    = 1'b0;
                    state_d  = S_IDLE;
                end
            end

            S_BERR: begin
                if (AS_L) begin
                    berr_n_d = 1'b1;
                    state_d  = S_IDLE;
                end
            end

            default: begin
                select_d = '0;
                hit_d    = 1'b0;
                berr_n_d = 1'b1;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q    <= S_IDLE;
            select_q   <= '0;
            hit_q      <= 1'b0;
            berr_n_q   <= 1'b1;
            err_addr_q <= '0;
            err_cnt_q  <= '0;
            timer_q    <= '0;
            for (int i = 0; i < NUM_REGIONS; i++) begin
                base_q[i] <= RESET_BASE[i*ADDR_WIDTH +: ADDR_WIDTH];
                mask_q[i] <= RESET_MASK[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end else begin
            state_q    <= state_d;
            select_q   <= select_d;
            hit_q      <= hit_d;
            berr_n_q   <= berr_n_d;
            err_addr_q <= err_addr_d;
            err_cnt_q  <= err_cnt_d;
            timer_q    <= timer_d;
            for (int i = 0; i < NUM_REGIONS; i++) begin
                base_q[i] <= base_d[i];
                mask_q[i] <= mask_d[i];
            end
        end
    end

    assign Select_H     = select_q;
    assign Hit_H        = hit_q;
    assign BusError_L   = berr_n_q;
    assign ErrorAddress = err_addr_q;
    assign ErrorCount   = err_cnt_q;

endmodule

// File: tb/tb_programmable_address_decoder.sv
module tb_programmable_address_decoder;

    localparam int N = 8;
    localparam int T = 1024;

    logic        clk = 1'b0;
    logic        rst_l;
    logic [31:0] address;
    logic        as_l;
    logic        dtack_l;
    logic        cfg_wr;
    logic [2:0]  cfg_idx;
    logic        cfg_is_mask;
    logic [31:0] cfg_data;
    logic [7:0]  select_h;
    logic        hit_h;
    logic        berr_l;
    logic [31:0] err_addr;
    logic [7:0]  err_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        is_err;
        logic [7:0]  sel;
        logic [31:0] addr;
        logic [7:0]  cnt;
    } ev_t;

    ev_t exp_q[$];

    // Reference map: a decode is "first region whose masked bits agree".
    logic [31:0] m_base [N];
    logic [31:0] m_mask [N];
    int          m_cnt;

    always #5 clk = ~clk;

    programmable_address_decoder dut (
        .Clock       (clk),
        .Reset_L     (rst_l),
        .Address     (address),
        .AS_L        (as_l),
        .Dtack_L     (dtack_l),
        .CfgWrite_H  (cfg_wr),
        .CfgIndex    (cfg_idx),
        .CfgIsMask_H (cfg_is_mask),
        .CfgData     (cfg_data),
        .Select_H    (select_h),
        .Hit_H       (hit_h),
        .BusError_L  (berr_l),
        .ErrorAddress(err_addr),
        .ErrorCount  (err_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic void model_reset();
        m_base = '{32'h0000_0000, 32'h0040_0000, 32'h0800_0000, 32'hF000_0000,
                   32'h0050_0000, 32'h0, 32'h0, 32'h0};
        m_mask = '{32'hFFFF_8000, 32'hFFFF_0000, 32'hFC00_0000, 32'hFFFC_0000,
                   32'hFFFF_0000, 32'h0, 32'h0, 32'h0};
        m_cnt  = 0;
    endfunction

    function automatic int region_of(input logic [31:0] a);
        for (int i = 0; i < N; i++) begin
            if (m_mask[i] != 32'h0 && ((a ^ m_base[i]) & m_mask[i]) == 32'h0) return i;
        end
        return -1;
    endfunction

    task automatic push_sel(input int r);
        ev_t e;
        e = '0;
        e.sel = 8'b1 << r;
        exp_q.push_back(e);
    endtask

    task automatic push_err(input logic [31:0] a);
        ev_t e;
        e = '0;
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        e.is_err = 1'b1;
        e.addr   = a;
        e.cnt    = 8'(m_cnt);
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Monitor: a rising Hit_H presents a select, a falling BusError_L presents a fault.
    logic prev_hit    = 1'b0;
    logic prev_berr_l = 1'b1;

    task automatic mon_event(input logic is_err);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected actual=is_err:%0b sel:%h required=no_event", is_err, select_h);
            return;
        end
        e = exp_q.pop_front();
        chk("sb_kind", 32'(is_err), 32'(e.is_err));
        chk("sb_sel", 32'(select_h), 32'(e.sel));
        if (is_err) begin
            chk("sb_err_addr", err_addr, e.addr);
            chk("sb_err_cnt", 32'(err_cnt), 32'(e.cnt));
        end
    endtask

    always @(negedge clk) begin
        if (!rst_l) begin
            prev_hit    = 1'b0;
            prev_berr_l = 1'b1;
        end else begin
            if (hit_h && !prev_hit) mon_event(1'b0);
            if (!berr_l && prev_berr_l) mon_event(1'b1);
            prev_hit    = hit_h;
            prev_berr_l = berr_l;
        end
    end

    task automatic cfg(input int idx, input logic is_mask, input logic [31:0] d);
        cfg_wr      = 1'b1;
        cfg_idx     = 3'(idx);
        cfg_is_mask = is_mask;
        cfg_data    = d;
        tick();
        cfg_wr = 1'b0;
        if (is_mask) m_mask[idx] = d;
        else         m_base[idx] = d;
    endtask

    // mode >= 0: ack after that many clocks; -1: never ack; -2: abort while waiting.
    task automatic access(input logic [31:0] a, input int mode);
        int r;
        r = region_of(a);
        address = a;
        as_l    = 1'b0;
        if (r >= 0) push_sel(r);
        if (r < 0 || (r >= 0 && mode == -1)) push_err(a);
        tick();
        tick();
        chk("sel_2nd_edge", 32'(select_h), (r >= 0) ? (32'd1 << r) : 32'd0);
        chk("hit_2nd_edge", 32'(hit_h), (r >= 0) ? 32'd1 : 32'd0);
        if (r < 0) begin
            chk("berr_unmapped", 32'(berr_l), 32'd0);
        end else if (mode == -1) begin
            repeat (T - 1) tick();
            chk("berr_before_timeout", 32'(berr_l), 32'd1);
            tick();
            chk("berr_at_timeout", 32'(berr_l), 32'd0);
            chk("sel_clear_timeout", 32'(select_h), 32'd0);
        end else if (mode == -2) begin
            tick();
            tick();
        end else begin
            repeat (mode) tick();
            dtack_l = 1'b0;
            tick();
            chk("berr_after_ack", 32'(berr_l), 32'd1);
            chk("sel_held_acked", 32'(select_h), 32'd1 << r);
        end
        as_l    = 1'b1;
        dtack_l = 1'b1;
        tick();
        chk("sel_idle", 32'(select_h), 32'd0);
        chk("hit_idle", 32'(hit_h), 32'd0);
        chk("berr_idle", 32'(berr_l), 32'd1);
        tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] ones;
        int          j;
        int          mode;
        int unsigned pick;

        ones        = '1;
        rst_l       = 1'b0;
        address     = '0;
        as_l        = 1'b1;
        dtack_l     = 1'b1;
        cfg_wr      = 1'b0;
        cfg_idx     = '0;
        cfg_is_mask = 1'b0;
        cfg_data    = '0;
        model_reset();

        repeat (2) @(posedge clk);
        #2;
        chk("rst_sel", 32'(select_h), 32'd0);
        chk("rst_hit", 32'(hit_h), 32'd0);
        chk("rst_berr", 32'(berr_l), 32'd1);
        chk("rst_err_addr", err_addr, 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst_l = 1'b1;
        tick();

        access(32'h0040_0010, 0);          // r1
        access(32'h0800_1234, 3);          // r2
        access(32'h0060_0000, 0);          // unmapped
        chk("err_addr_unmapped", err_addr, 32'h0060_0000);
        chk("err_cnt_first", 32'(err_cnt), 32'd1);
        access(32'hF000_0000, -1);         // timeout
        access(32'hF000_0000, T - 1);      // ack on the expiry clock
        access(32'h0000_1000, -2);         // abort, no error

        // Map writes while a cycle sits in ACKED leave its select alone.
        address = 32'h0040_0010;
        as_l    = 1'b0;
        push_sel(region_of(address));
        tick();
        tick();
        dtack_l = 1'b0;
        tick();
        cfg(5, 1'b0, 32'h0060_0000);
        cfg(5, 1'b1, 32'hFFFF_0000);
        chk("acked_sel_unchanged", 32'(select_h), 32'h02);
        as_l    = 1'b1;
        dtack_l = 1'b1;
        tick();
        tick();
        access(32'h0060_0000, 1);          // now r5

        // A mask write in the DECODE clock is not seen by that decode.
        cfg(6, 1'b0, 32'h0070_0000);
        address = 32'h0070_0000;
        as_l    = 1'b0;
        push_err(address);
        tick();
        cfg_wr      = 1'b1;
        cfg_idx     = 3'd6;
        cfg_is_mask = 1'b1;
        cfg_data    = 32'hFFFF_0000;
        tick();
        cfg_wr    = 1'b0;
        m_mask[6] = 32'hFFFF_0000;
        chk("decode_ignores_same_clk_cfg", 32'(berr_l), 32'd0);
        as_l = 1'b1;
        tick();
        tick();
        access(32'h0070_0000, 0);          // r6

        for (int n = 0; n < 150; n++) begin
            pick = $urandom_range(0, 9);
            if (pick == 0) begin
                j = $urandom_range(5, 7);
                if ($urandom_range(0, 1) == 1) begin
                    mode = $urandom_range(0, 20);
                    cfg(j, 1'b1, (mode == 0) ? 32'h0 : (ones << (mode + 8)));
                end else begin
                    cfg(j, 1'b0, $urandom);
                end
            end else begin
                j = $urandom_range(0, N - 1);
                if (pick < 7 && m_mask[j] != 32'h0)
                    a = (m_base[j] & m_mask[j]) | ($urandom & ~m_mask[j]);
                else
                    a = $urandom;
                mode = ($urandom_range(0, 9) == 0) ? -2 : int'($urandom_range(0, 6));
                access(a, mode);
            end
        end

        cfg(5, 1'b0, 32'h0060_0000);
        cfg(5, 1'b1, 32'hFFFF_0000);
        cfg(6, 1'b1, 32'h0);
        cfg(7, 1'b1, 32'h0);
        access(32'h0060_0000, 0);          // r5 enabled before the reset

        while (m_cnt < 255) access(32'hA000_0000 | 32'($urandom_range(0, 255)), 0);
        access(32'hA000_0040, 0);          // 256th fault holds at 255
        chk("err_cnt_saturated", 32'(err_cnt), 32'd255);

        address = 32'hA000_0100;
        as_l    = 1'b0;
        push_err(address);
        tick();
        tick();
        chk("berr_before_reset", 32'(berr_l), 32'd0);
        chk("err_cnt_held", 32'(err_cnt), 32'd255);
        tick();
        rst_l = 1'b0;
        #1;
        chk("arst_sel", 32'(select_h), 32'd0);
        chk("arst_hit", 32'(hit_h), 32'd0);
        chk("arst_berr", 32'(berr_l), 32'd1);
        chk("arst_err_addr", err_addr, 32'd0);
        chk("arst_err_cnt", 32'(err_cnt), 32'd0);
        model_reset();
        as_l = 1'b1;
        tick();
        rst_l = 1'b1;
        tick();

        access(32'h0060_0000, 0);          // r5 back to disabled
        access(32'h0040_0010, 2);          // default map intact

        repeat (3) tick();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
